// File: rtl/uart_pkg.sv
// Shared constants and FSM state encoding for the UART RX packet loader.
package uart_pkg;

    localparam int UART_BYTE_W = 8;
    localparam int UART_WORD_W = 32;

    localparam logic [UART_BYTE_W-1:0] UART_SYNC_BYTE = 8'hA5;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CMD     = 3'd1,
        ST_ADDR_HI = 3'd2,
        ST_ADDR_LO = 3'd3,
        ST_LEN     = 3'd4,
        ST_DATA    = 3'd5,
        ST_CHK     = 3'd6
    } uart_state_e;

endpackage

// File: rtl/uart_rx_word_packer.sv
// Packs little-endian payload bytes into 32-bit words; exposes the word that
// the current byte completes so the caller can register it in the same cycle.
module uart_rx_word_packer
    import uart_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   byte_valid,
    input  logic [UART_BYTE_W-1:0] byte_in,
    output logic [UART_WORD_W-1:0] word_next,
    output logic                   word_ready
);

    logic [UART_WORD_W-1:0] shift_reg;
    logic [1:0]             byte_cnt_reg;

    // New bytes enter at the top, so the first byte ends up in bits [7:0].
    assign word_next  = {byte_in, shift_reg[UART_WORD_W-1:UART_BYTE_W]};
    assign word_ready = byte_valid && !clear && (byte_cnt_reg == 2'd3);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            shift_reg    <= '0;
            byte_cnt_reg <= 2'd0;
        end else if (clear) begin
            shift_reg    <= '0;
            byte_cnt_reg <= 2'd0;
        end else if (byte_valid) begin
            shift_reg    <= word_next;
            byte_cnt_reg <= byte_cnt_reg + 2'd1;
        end
    end

endmodule

// File: rtl/uart_rx_pkt_loader.sv
// Framed packet parser: SYNC, CMD, BASE_HI, BASE_LO, LEN, LEN*4 payload [, CHK].
// Checksum byte and its check exist only when UART_RX_PKT_CHECKSUM_EN is defined.
module uart_rx_pkt_loader
    import uart_pkg::*;
#(
    parameter int                   ADDR_W      = 12,
    parameter int                   TIMEOUT_CYC = 50000,
    parameter logic [UART_BYTE_W-1:0] SYNC_BYTE = UART_SYNC_BYTE
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx_done_sig,
    input  logic [UART_BYTE_W-1:0] rx_data,
    output logic                   wr_en,
    output logic [ADDR_W-1:0]      wr_addr,
    output logic [UART_WORD_W-1:0] wr_data,
    output logic [UART_BYTE_W-1:0] pkt_cmd,
    output logic                   busy,
    output logic                   pkt_done,
    output logic                   pkt_err
);

    localparam logic [2:0] S_IDLE    = ST_IDLE;
    localparam logic [2:0] S_CMD     = ST_CMD;
    localparam logic [2:0] S_ADDR_HI = ST_ADDR_HI;
    localparam logic [2:0] S_ADDR_LO = ST_ADDR_LO;
    localparam logic [2:0] S_LEN     = ST_LEN;
    localparam logic [2:0] S_DATA    = ST_DATA;
`ifdef UART_RX_PKT_CHECKSUM_EN
    localparam logic [2:0] S_CHK     = ST_CHK;
`endif

    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic                   rx_prev_reg;
    logic                   byte_edge;
    logic [2:0]             state_reg;
    logic [UART_BYTE_W-1:0] base_hi_reg;
    logic [ADDR_W-1:0]      addr_reg;
    logic [UART_BYTE_W-1:0] len_reg;
    logic [UART_BYTE_W-1:0] word_cnt_reg;
    logic [CNT_W-1:0]       idle_cnt_reg;
    logic                   timeout_hit;
    logic                   last_word;
    logic                   packer_clear;
    logic                   packer_valid;
    logic [UART_WORD_W-1:0] packer_word;
    logic                   packer_ready;
    logic [2*UART_BYTE_W+ADDR_W-1:0] base_ext;
`ifdef UART_RX_PKT_CHECKSUM_EN
    logic [UART_BYTE_W-1:0] chk_reg;
`endif

    assign byte_edge    = rx_done_sig && !rx_prev_reg;
    // A byte arriving in the expiry cycle takes priority over the timeout.
    assign timeout_hit  = (state_reg != S_IDLE) && !byte_edge &&
                          (idle_cnt_reg == CNT_W'(TIMEOUT_CYC - 1));
    assign last_word    = (word_cnt_reg == (len_reg - 8'd1));
    assign packer_clear = (state_reg != S_DATA) || timeout_hit;
    assign packer_valid = byte_edge && (state_reg == S_DATA);
    assign base_ext     = {{ADDR_W{1'b0}}, base_hi_reg, rx_data};

    uart_rx_word_packer u_packer (
        .clock      (clock),
        .reset      (reset),
        .clear      (packer_clear),
        .byte_valid (packer_valid),
        .byte_in    (rx_data),
        .word_next  (packer_word),
        .word_ready (packer_ready)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rx_prev_reg  <= 1'b0;
            idle_cnt_reg <= '0;
        end else begin
            rx_prev_reg <= rx_done_sig;
            if (byte_edge || (state_reg == S_IDLE))
                idle_cnt_reg <= '0;
            else
                idle_cnt_reg <= idle_cnt_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= S_IDLE;
            base_hi_reg  <= '0;
            addr_reg     <= '0;
            len_reg      <= '0;
            word_cnt_reg <= '0;
            wr_en        <= 1'b0;
            wr_addr      <= '0;
            wr_data      <= '0;
            pkt_cmd      <= '0;
            busy         <= 1'b0;
            pkt_done     <= 1'b0;
            pkt_err      <= 1'b0;
`ifdef UART_RX_PKT_CHECKSUM_EN
            chk_reg      <= '0;
`endif
        end else begin
            wr_en    <= 1'b0;
            pkt_done <= 1'b0;
            pkt_err  <= 1'b0;
            if (timeout_hit) begin
                state_reg <= S_IDLE;
                busy      <= 1'b0;
                pkt_err   <= 1'b1;
            end else if (byte_edge) begin
                case (state_reg)
                    S_IDLE: begin
                        if (rx_data == SYNC_BYTE) begin
                            state_reg <= S_CMD;
                            busy      <= 1'b1;
                        end
                    end
                    S_CMD: begin
                        pkt_cmd   <= rx_data;
                        state_reg <= S_ADDR_HI;
`ifdef UART_RX_PKT_CHECKSUM_EN
                        chk_reg   <= rx_data;
`endif
                    end
                    S_ADDR_HI: begin
                        base_hi_reg <= rx_data;
                        state_reg   <= S_ADDR_LO;
`ifdef UART_RX_PKT_CHECKSUM_EN
                        chk_reg     <= chk_reg ^ rx_data;
`endif
                    end
                    S_ADDR_LO: begin
                        addr_reg  <= base_ext[ADDR_W-1:0];
                        state_reg <= S_LEN;
`ifdef UART_RX_PKT_CHECKSUM_EN
                        chk_reg   <= chk_reg ^ rx_data;
`endif
                    end
                    S_LEN: begin
`ifdef UART_RX_PKT_CHECKSUM_EN
                        chk_reg <= chk_reg ^ rx_data;
`endif
                        if (rx_data == 8'd0) begin
                            state_reg <= S_IDLE;
                            busy      <= 1'b0;
                            pkt_err   <= 1'b1;
                        end else begin
                            len_reg      <= rx_data;
                            word_cnt_reg <= '0;
                            state_reg    <= S_DATA;
                        end
                    end
                    S_DATA: begin
`ifdef UART_RX_PKT_CHECKSUM_EN
                        chk_reg <= chk_reg ^ rx_data;
`endif
                        if (packer_ready) begin
                            wr_en        <= 1'b1;
                            wr_addr      <= addr_reg;
                            wr_data      <= packer_word;
                            addr_reg     <= addr_reg + ADDR_W'(1);
                            word_cnt_reg <= word_cnt_reg + 8'd1;
                            if (last_word) begin
`ifdef UART_RX_PKT_CHECKSUM_EN
                                state_reg <= S_CHK;
`else
                                state_reg <= S_IDLE;
                                busy      <= 1'b0;
                                pkt_done  <= 1'b1;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PKT_CHECKSUM_EN
                    S_CHK: begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                        if (rx_data == chk_reg)
                            pkt_done <= 1'b1;
                        else
                            pkt_err  <= 1'b1;
                    end
`endif
                    default: begin
                        state_reg <= S_IDLE;
                        busy      <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
